// File: rtl/iob_uart16550_ctrl_pkg.sv
// Shared constants and state encoding for the iob_uart16550 CSR-bus controller.
package iob_uart16550_ctrl_pkg;

    localparam int unsigned REG_RBR_THR_DLL = 0;
    localparam int unsigned REG_IER_DLM     = 1;
    localparam int unsigned REG_FCR         = 2;
    localparam int unsigned REG_LCR         = 3;
    localparam int unsigned REG_LSR         = 5;

    localparam int unsigned LSR_DR   = 0;
    localparam int unsigned LSR_THRE = 5;

    localparam logic [7:0] LCR_DLAB = 8'h83;
    localparam logic [7:0] LCR_8N1  = 8'h03;
    localparam logic [7:0] FCR_INIT = 8'h07;

    typedef enum logic [3:0] {
        INIT_LCR_DLAB,
        INIT_DLL,
        INIT_DLM,
        INIT_LCR,
        INIT_FCR,
        INIT_IER,
        IDLE,
        POLL_LSR,
        LSR_WAIT,
        WR_THR,
        RD_RBR,
        RBR_WAIT
    } state_e;

endpackage

// File: rtl/iob_uart16550_ctrl_lane.sv
// Byte-lane steering between a single CSR byte and the 32-bit IOb data bus.
module iob_uart16550_ctrl_lane #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [LANE_W-1:0]   addr_i,
    input  logic [7:0]          byte_i,
    input  logic                write_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic [7:0]          rbyte_o
);

    always_comb begin
        wdata_o = {(DATA_W / 8){byte_i}};
        wstrb_o = '0;
        if (write_i) begin
            wstrb_o[addr_i] = 1'b1;
        end
        rbyte_o = rdata_i[8*addr_i +: 8];
    end

endmodule

// File: rtl/iob_uart16550_ctrl.sv
// Autonomous CSR manager: initialises an iob_uart16550, then polls LSR and
// moves bytes between the UART and a TX/RX stream pair with round-robin service.
module iob_uart16550_ctrl
    import iob_uart16550_ctrl_pkg::*;
#(
    parameter logic [15:0] DIV_RST  = 16'd27,
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cke_i,
    input  logic                init_i,
    input  logic [15:0]         div_i,
    output logic                init_done_o,
    input  logic [7:0]          tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic [7:0]          rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                iob_valid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i
);

    localparam int unsigned LANE_W = $clog2(DATA_W / 8);
    localparam int unsigned GAP_W  = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP);

    state_e            state_q, state_d;
    logic [15:0]       div_q, div_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              last_rx_q, last_rx_d;
    logic              served_q, served_d;
    logic              init_done_q, init_done_d;
    logic              rx_valid_q, rx_valid_d;
    logic [7:0]        rx_data_q, rx_data_d;

    logic              req, req_wr, fire, tx_ready;
    logic              lsr_eval, rbr_load, go_idle, tx_ok, rx_ok, pick_rx;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        wbyte, rbyte;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W/8-1:0] lane_wstrb;

    iob_uart16550_ctrl_lane #(
        .DATA_W(DATA_W),
        .LANE_W(LANE_W)
    ) u_lane (
        .addr_i (cur_addr[LANE_W-1:0]),
        .byte_i (wbyte),
        .write_i(req_wr),
        .rdata_i(iob_rdata_i),
        .wdata_o(lane_wdata),
        .wstrb_o(lane_wstrb),
        .rbyte_o(rbyte)
    );

    // Wait states keep their read address so the lane extractor picks the right byte.
    always_comb begin
        req      = 1'b0;
        req_wr   = 1'b0;
        cur_addr = '0;
        wbyte    = '0;
        case (state_q)
            INIT_LCR_DLAB: begin req = 1'b1; req_wr = 1'b1; cur_addr = ADDR_W'(REG_LCR);         wbyte = LCR_DLAB;    end
            INIT_DLL:      begin req = 1'b1; req_wr = 1'b1; cur_addr = ADDR_W'(REG_RBR_THR_DLL); wbyte = div_q[7:0];  end
            INIT_DLM:      begin req = 1'b1; req_wr = 1'b1; cur_addr = ADDR_W'(REG_IER_DLM);     wbyte = div_q[15:8]; end
            INIT_LCR:      begin req = 1'b1; req_wr = 1'b1; cur_addr = ADDR_W'(REG_LCR);         wbyte = LCR_8N1;     end
            INIT_FCR:      begin req = 1'b1; req_wr = 1'b1; cur_addr = ADDR_W'(REG_FCR);         wbyte = FCR_INIT;    end
            INIT_IER:      begin req = 1'b1; req_wr = 1'b1; cur_addr = ADDR_W'(REG_IER_DLM);     wbyte = 8'h00;       end
            POLL_LSR:      begin req = 1'b1; cur_addr = ADDR_W'(REG_LSR); end
            LSR_WAIT:      begin cur_addr = ADDR_W'(REG_LSR); end
            WR_THR:        begin req = 1'b1; req_wr = 1'b1; cur_addr = ADDR_W'(REG_RBR_THR_DLL); wbyte = tx_data_i;   end
            RD_RBR:        begin req = 1'b1; cur_addr = ADDR_W'(REG_RBR_THR_DLL); end
            RBR_WAIT:      begin cur_addr = ADDR_W'(REG_RBR_THR_DLL); end
            default:       ;
        endcase
    end

    assign fire  = cke_i & req & iob_ready_i;
    assign tx_ok = rbyte[LSR_THRE] & tx_valid_i;
    assign rx_ok = rbyte[LSR_DR] & ~rx_valid_q;
    // Ties alternate on last_rx; before anything has been served TX wins.
    assign pick_rx = rx_ok & (~tx_ok | (served_q & ~last_rx_q));

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        gap_d       = gap_q;
        last_rx_d   = last_rx_q;
        served_d    = served_q;
        init_done_d = init_done_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        tx_ready    = 1'b0;
        lsr_eval    = 1'b0;
        rbr_load    = 1'b0;
        go_idle     = 1'b0;
        if (cke_i) begin
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_d = 1'b0;
            end
            case (state_q)
                INIT_LCR_DLAB: if (fire) state_d = INIT_DLL;
                INIT_DLL:      if (fire) state_d = INIT_DLM;
                INIT_DLM:      if (fire) state_d = INIT_LCR;
                INIT_LCR:      if (fire) state_d = INIT_FCR;
                INIT_FCR:      if (fire) state_d = INIT_IER;
                INIT_IER: begin
                    if (fire) begin
                        init_done_d = 1'b1;
                        go_idle     = 1'b1;
                    end
                end
                IDLE: begin
                    if (init_i) begin
                        init_done_d = 1'b0;
                        div_d       = div_i;
                        state_d     = INIT_LCR_DLAB;
                    end else if (gap_q != '0) begin
                        gap_d = gap_q - GAP_W'(1);
                    end else if (tx_valid_i || !rx_valid_q) begin
                        state_d = POLL_LSR;
                    end
                end
                POLL_LSR: begin
                    if (fire) begin
                        if (iob_rvalid_i) lsr_eval = 1'b1;
                        else              state_d  = LSR_WAIT;
                    end
                end
                LSR_WAIT: if (iob_rvalid_i) lsr_eval = 1'b1;
                WR_THR: begin
                    if (fire) begin
                        tx_ready  = 1'b1;
                        last_rx_d = 1'b0;
                        served_d  = 1'b1;
                        go_idle   = 1'b1;
                    end
                end
                RD_RBR: begin
                    if (fire) begin
                        if (iob_rvalid_i) rbr_load = 1'b1;
                        else              state_d  = RBR_WAIT;
                    end
                end
                RBR_WAIT: if (iob_rvalid_i) rbr_load = 1'b1;
                default:  state_d = INIT_LCR_DLAB;
            endcase

            if (lsr_eval) begin
                if (pick_rx)    state_d = RD_RBR;
                else if (tx_ok) state_d = WR_THR;
                else            go_idle = 1'b1;
            end
            if (rbr_load) begin
                rx_data_d  = rbyte;
                rx_valid_d = 1'b1;
                last_rx_d  = 1'b1;
                served_d   = 1'b1;
                go_idle    = 1'b1;
            end
            if (go_idle) begin
                state_d = IDLE;
                gap_d   = GAP_LOAD;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= INIT_LCR_DLAB;
            div_q       <= DIV_RST;
            gap_q       <= GAP_LOAD;
            last_rx_q   <= 1'b0;
            served_q    <= 1'b0;
            init_done_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            last_rx_q   <= last_rx_d;
            served_q    <= served_d;
            init_done_q <= init_done_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
        end
    end

    // Outputs are forced low for the whole time rst_n_i is held, not just after the edge.
    assign iob_valid_o = rst_n_i & req;
    assign iob_addr_o  = iob_valid_o ? cur_addr : '0;
    assign iob_wdata_o = (iob_valid_o && req_wr) ? lane_wdata : '0;
    assign iob_wstrb_o = iob_valid_o ? lane_wstrb : '0;
    assign tx_ready_o  = rst_n_i & tx_ready;
    assign init_done_o = rst_n_i & init_done_q;
    assign rx_valid_o  = rst_n_i & rx_valid_q;
    assign rx_data_o   = rst_n_i ? rx_data_q : '0;

endmodule

// File: tb/tb_iob_uart16550_ctrl.sv
// Directed bench for iob_uart16550_ctrl with a behavioural UART CSR responder.
module tb_iob_uart16550_ctrl;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cke_i = 1'b1;
    logic        init_i = 1'b0;
    logic [15:0] div_i = 16'h0;
    logic        init_done_o;
    logic [7:0]  tx_data_i = 8'h0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        iob_valid_o;
    logic [4:0]  iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_rvalid_i = 1'b0;
    logic [31:0] iob_rdata_i = 32'h0;
    logic        iob_ready_i = 1'b0;

    iob_uart16550_ctrl #(
        .DIV_RST (16'd27),
        .POLL_GAP(4),
        .ADDR_W  (5),
        .DATA_W  (32)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .cke_i       (cke_i),
        .init_i      (init_i),
        .div_i       (div_i),
        .init_done_o (init_done_o),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .iob_valid_o (iob_valid_o),
        .iob_addr_o  (iob_addr_o),
        .iob_wdata_o (iob_wdata_o),
        .iob_wstrb_o (iob_wstrb_o),
        .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i (iob_rdata_i),
        .iob_ready_i (iob_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } ent_t;

    ent_t log_q[$];
    ent_t snap;
    int   checks = 0;
    int   failures = 0;
    int   rdy_dly = 0;
    int   rv_dly = 0;
    int   rv_cnt = 0;
    int   stall_cnt = 0;
    int   tx_ready_cnt = 0;
    int   stall_cycles = 0;
    int   stab_err = 0;
    logic [7:0] lsr_val = 8'h00;
    logic [7:0] rbr_val = 8'h00;
    bit   acc;
    bit   prev_pend = 1'b0;
    logic [40:0] prev_req = '0;

    function automatic logic [31:0] rd_word(input logic [4:0] a);
        logic [31:0] w;
        w = 32'hEEEE_EEEE;
        if (a == 5'd5) w[15:8] = lsr_val;
        else if (a == 5'd0) w[7:0] = rbr_val;
        return w;
    endfunction

    // UART CSR responder: programmable ready and rvalid latency, logs accepted requests.
    always @(negedge clk) begin
        acc = iob_ready_i;
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = rd_word(snap.addr);
            end
        end
        if (acc) begin
            log_q.push_back(snap);
            if (snap.wstrb == 4'b0 && rv_dly > 0) rv_cnt = rv_dly;
        end
        if (iob_valid_o && rst_n_i) begin
            if (stall_cnt < rdy_dly) begin
                stall_cnt++;
            end else begin
                stall_cnt   = 0;
                iob_ready_i = 1'b1;
                snap = '{iob_addr_o, iob_wdata_o, iob_wstrb_o};
                if (iob_wstrb_o == 4'b0 && rv_dly == 0) begin
                    iob_rvalid_i = 1'b1;
                    iob_rdata_i  = rd_word(iob_addr_o);
                end
            end
        end else begin
            stall_cnt = 0;
        end
    end

    // Mid-cycle sampler, two time units before each rising edge.
    always @(negedge clk) begin
        #3;
        if (tx_ready_o) tx_ready_cnt++;
        if (iob_valid_o && !iob_ready_i) stall_cycles++;
        if (prev_pend && rst_n_i &&
            (!iob_valid_o || prev_req !== {iob_addr_o, iob_wdata_o, iob_wstrb_o})) stab_err++;
        prev_pend = iob_valid_o && !iob_ready_i && rst_n_i;
        prev_req  = {iob_addr_o, iob_wdata_o, iob_wstrb_o};
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ent_sig(input int idx);
        logic [31:0] t;
        if (idx < 0 || idx >= log_q.size()) return 17'h1FFFF;
        t = log_q[idx].wdata >> (8 * log_q[idx].addr[1:0]);
        return {log_q[idx].addr, t[7:0], log_q[idx].wstrb};
    endfunction

    function automatic int count_since(input int m, input logic [4:0] a, input bit wr);
        int n = 0;
        for (int i = m; i < log_q.size(); i++)
            if (log_q[i].addr == a && ((log_q[i].wstrb != 4'b0) == wr)) n++;
        return n;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int   mark;
        int   base;
        int   n;
        logic [3:0]  kinds;
        logic [15:0] thr_bytes;

        // Reset: all outputs low while rst_n_i is held.
        tick(3);
        chk("reset_outputs", {iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, tx_ready_o,
                              rx_valid_o, rx_data_o, init_done_o}, 64'h0);
        chk("reset_init_done", init_done_o, 1'b0);

        // Init sequence with the reset divisor.
        mark = log_q.size();
        rst_n_i = 1'b1;
        for (int i = 0; i < 200 && !init_done_o; i++) tick();
        chk("init_done_timeout", init_done_o, 1'b1);
        tick(2);
        chk("init_w0", ent_sig(mark + 0), {5'd3, 8'h83, 4'b1000});
        chk("init_w1", ent_sig(mark + 1), {5'd0, 8'h1B, 4'b0001});
        chk("init_w2", ent_sig(mark + 2), {5'd1, 8'h00, 4'b0010});
        chk("init_w3", ent_sig(mark + 3), {5'd3, 8'h03, 4'b1000});
        chk("init_w4", ent_sig(mark + 4), {5'd2, 8'h07, 4'b0100});
        chk("init_w5", ent_sig(mark + 5), {5'd1, 8'h00, 4'b0010});

        // TX: single byte, THRE set.
        mark = log_q.size();
        base = tx_ready_cnt;
        lsr_val = 8'h20;
        tx_data_i = 8'h55;
        tx_valid_i = 1'b1;
        for (int i = 0; i < 200 && tx_ready_cnt == base; i++) tick();
        tx_valid_i = 1'b0;
        lsr_val = 8'h00;
        tick(30);
        chk("tx_ready_pulses", tx_ready_cnt - base, 1);
        chk("tx_thr_writes", count_since(mark, 5'd0, 1'b1), 1);
        n = -1;
        for (int i = mark; i < log_q.size(); i++)
            if (log_q[i].addr == 5'd0 && log_q[i].wstrb != 4'b0 && n < 0) n = i;
        chk("tx_thr_write", ent_sig(n), {5'd0, 8'h55, 4'b0001});
        chk("tx_lsr_read_strb", (count_since(mark, 5'd5, 1'b0) > 0), 1'b1);

        // RX: data ready, consumer stalled.
        mark = log_q.size();
        rbr_val = 8'hA3;
        lsr_val = 8'h01;
        for (int i = 0; i < 200 && !rx_valid_o; i++) tick();
        chk("rx_valid", rx_valid_o, 1'b1);
        chk("rx_data", rx_data_o, 8'hA3);
        tick(40);
        chk("rx_single_rbr_read", count_since(mark, 5'd0, 1'b0), 1);
        chk("rx_held", {rx_valid_o, rx_data_o}, {1'b1, 8'hA3});
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        chk("rx_cleared", rx_valid_o, 1'b0);
        tick(40);
        chk("rx_reread_after_take", count_since(mark, 5'd0, 1'b0), 2);

        // Arbitration: LSR reports both THRE and DR, two TX bytes pending.
        lsr_val = 8'h00;
        rx_ready_i = 1'b1;
        tick(20);
        mark = log_q.size();
        base = tx_ready_cnt;
        rbr_val = 8'h3C;
        lsr_val = 8'h21;
        tx_data_i = 8'h10;
        tx_valid_i = 1'b1;
        for (int i = 0; i < 400 && tx_valid_i; i++) begin
            tick();
            if (tx_ready_cnt - base == 1) tx_data_i = 8'h11;
            if (tx_ready_cnt - base >= 2) tx_valid_i = 1'b0;
        end
        chk("arb_tx_done", tx_valid_i, 1'b0);
        tick(40);
        n = 0;
        kinds = 4'hF;
        thr_bytes = 16'h0;
        for (int i = mark; i < log_q.size() && n < 4; i++) begin
            if (log_q[i].addr == 5'd0) begin
                kinds[3 - n] = (log_q[i].wstrb == 4'b0);
                if (log_q[i].wstrb != 4'b0) thr_bytes = {thr_bytes[7:0], log_q[i].wdata[7:0]};
                n++;
            end
        end
        chk("arb_order", kinds, 4'b0101);
        chk("arb_thr_bytes", thr_bytes, 16'h1011);

        // Stall: delayed ready and rvalid, controller quiescent beforehand.
        rx_ready_i = 1'b0;
        tick(30);
        rdy_dly = 3;
        rv_dly = 2;
        rbr_val = 8'h5C;
        lsr_val = 8'h01;
        stab_err = 0;
        mark = log_q.size();
        base = stall_cycles;
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        for (int i = 0; i < 200 && !rx_valid_o; i++) tick();
        tick(10);
        chk("stall_rx_data", {rx_valid_o, rx_data_o}, {1'b1, 8'h5C});
        chk("stall_stable", stab_err, 0);
        chk("stall_txn_count", log_q.size() - mark, 2);
        chk("stall_txn_seq", {ent_sig(mark), ent_sig(mark + 1)},
            {5'd5, 8'h00, 4'b0000, 5'd0, 8'h00, 4'b0000});
        chk("stall_cycles", stall_cycles - base, 6);

        // init_i from IDLE with a new divisor; RX holding register untouched.
        rdy_dly = 0;
        rv_dly = 0;
        mark = log_q.size();
        div_i = 16'h1234;
        init_i = 1'b1;
        tick();
        init_i = 1'b0;
        chk("reinit_done_clear", init_done_o, 1'b0);
        for (int i = 0; i < 200 && !init_done_o; i++) tick();
        tick(10);
        chk("reinit_count", log_q.size() - mark, 6);
        chk("reinit_dll_dlm", {ent_sig(mark), ent_sig(mark + 1), ent_sig(mark + 2)},
            {5'd3, 8'h83, 4'b1000, 5'd0, 8'h34, 4'b0001, 5'd1, 8'h12, 4'b0010});
        chk("reinit_rx_kept", {init_done_o, rx_valid_o, rx_data_o}, {1'b1, 1'b1, 8'h5C});

        // Reset while a THR write is stalled.
        rdy_dly = 6;
        lsr_val = 8'h20;
        tx_data_i = 8'h77;
        tx_valid_i = 1'b1;
        base = tx_ready_cnt;
        for (int i = 0; i < 300 && !(iob_valid_o && iob_addr_o == 5'd0 && iob_wstrb_o == 4'b0001); i++)
            tick();
        chk("rst_thr_pending", {iob_valid_o, iob_wstrb_o}, {1'b1, 4'b0001});
        rst_n_i = 1'b0;
        tick();
        chk("rst_mid_outputs", {iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, tx_ready_o,
                                rx_valid_o, rx_data_o, init_done_o}, 64'h0);
        tx_valid_i = 1'b0;
        rdy_dly = 0;
        mark = log_q.size();
        rst_n_i = 1'b1;
        for (int i = 0; i < 200 && !init_done_o; i++) tick();
        tick(2);
        chk("rst_restart_seq", {ent_sig(mark), ent_sig(mark + 1), ent_sig(mark + 2)},
            {5'd3, 8'h83, 4'b1000, 5'd0, 8'h1B, 4'b0001, 5'd1, 8'h00, 4'b0010});
        chk("rst_no_tx_accept", tx_ready_cnt - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
